// File: rtl/rate_meter_pkg.sv
// rate_meter_pkg: shared types and constants for the rate meter.
// Holds the FSM state encoding and default counter width.
package rate_meter_pkg;

  localparam int DEFAULT_WIDTH = 28;

  localparam logic [DEFAULT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    SAT     = 2'd2
  } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: one-bit history register, rise = level & ~history.
// Ports: clock, clear (async high), level in, rise strobe out.
module rising_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic clear,
  input  logic level,
  output logic rise
);

  logic hist;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) hist <= RESET_VAL;
    else       hist <= level;
  end

  assign rise = level & ~hist;

endmodule

// File: rtl/rate_meter.sv
// rate_meter: measures tick spacing, reports divider reload (period-1).
// Ports: clock, clear, restart, pulse_in -> divisor, divisor_valid,
// locked, overflow. RATE_METER_STATS_EN adds min_divisor/max_divisor.
module rate_meter
  import rate_meter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_MATCH = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             restart,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] divisor,
  output logic             divisor_valid,
  output logic             locked,
`ifdef RATE_METER_STATS_EN
  output logic [WIDTH-1:0] min_divisor,
  output logic [WIDTH-1:0] max_divisor,
`endif
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [3:0]       M_MAX   = 4'(LOCK_MATCH);

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] meas;
  logic             valid_n;
  logic             lock_n;
  logic             ovf_n;
  logic [3:0]       match, match_n;
  logic             rise;

`ifdef RATE_METER_STATS_EN
  logic [WIDTH-1:0] min_n, max_n;
`endif

  rising_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_edge (
    .clock(clock),
    .clear(clear),
    .level(pulse_in),
    .rise (rise)
  );

  assign meas = count - ONE;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state         <= IDLE;
      count         <= '0;
      divisor       <= '0;
      divisor_valid <= 1'b0;
      locked        <= 1'b0;
      overflow      <= 1'b0;
      match         <= 4'd0;
`ifdef RATE_METER_STATS_EN
      min_divisor   <= '1;
      max_divisor   <= '0;
`endif
    end else begin
      state         <= state_n;
      count         <= count_n;
      divisor       <= div_n;
      divisor_valid <= valid_n;
      locked        <= lock_n;
      overflow      <= ovf_n;
      match         <= match_n;
`ifdef RATE_METER_STATS_EN
      min_divisor   <= min_n;
      max_divisor   <= max_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    div_n   = divisor;
    valid_n = 1'b0;
    lock_n  = locked;
    ovf_n   = overflow;
    match_n = match;
`ifdef RATE_METER_STATS_EN
    min_n   = min_divisor;
    max_n   = max_divisor;
`endif
    if (restart) begin
      state_n = IDLE;
      count_n = '0;
      lock_n  = 1'b0;
      match_n = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_n = MEASURE;
            count_n = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            div_n   = meas;
            valid_n = 1'b1;
            ovf_n   = 1'b0;
            count_n = ONE;
            // match==0 marks the first interval after IDLE/SAT
            if (match == 4'd0)
              match_n = 4'd1;
            else if (meas == divisor)
              match_n = (match >= M_MAX) ? M_MAX
                                         : match + 4'd1;
            else
              match_n = 4'd1;
            lock_n = (match_n >= M_MAX);
`ifdef RATE_METER_STATS_EN
            if (meas < min_divisor) min_n = meas;
            if (meas > max_divisor) max_n = meas;
`endif
          end else if (count == CNT_MAX) begin
            state_n = SAT;
            ovf_n   = 1'b1;
            lock_n  = 1'b0;
            match_n = 4'd0;
          end else begin
            count_n = count + ONE;
          end
        end
        SAT: begin
          // interval spanning saturation is discarded
          if (rise) begin
            state_n = MEASURE;
            count_n = ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_meter.sv
// tb_rate_meter: directed checks of rate_meter at WIDTH=28 and WIDTH=8.
// Define RATE_METER_STATS_EN to also cover min/max tracking.
module tb_rate_meter;
  import rate_meter_pkg::*;

  logic        clock;
  logic        clear;
  logic        restart;
  logic        pulse;

  logic [27:0] d28;
  logic        v28, l28, o28;
  logic [7:0]  d8;
  logic        v8, l8, o8;
`ifdef RATE_METER_STATS_EN
  logic [27:0] mn28, mx28;
  logic [7:0]  mn8, mx8;
`endif

  int checks;
  int failures;

  rate_meter #(.WIDTH(28), .LOCK_MATCH(2)) u28 (
    .clock        (clock),
    .clear        (clear),
    .restart      (restart),
    .pulse_in     (pulse),
    .divisor      (d28),
    .divisor_valid(v28),
    .locked       (l28),
`ifdef RATE_METER_STATS_EN
    .min_divisor  (mn28),
    .max_divisor  (mx28),
`endif
    .overflow     (o28)
  );

  rate_meter #(.WIDTH(8), .LOCK_MATCH(2)) u8 (
    .clock        (clock),
    .clear        (clear),
    .restart      (restart),
    .pulse_in     (pulse),
    .divisor      (d8),
    .divisor_valid(v8),
    .locked       (l8),
`ifdef RATE_METER_STATS_EN
    .min_divisor  (mn8),
    .max_divisor  (mx8),
`endif
    .overflow     (o8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input logic p);
    pulse = p;
    @(negedge clock);
  endtask

  task automatic do_restart();
    pulse   = 1'b0;
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    int strobes;
    strobes = 0;
    clear   = 1'b1;
    restart = 1'b0;
    pulse   = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      if (v28 || v8) strobes++;
      checks++;
      if (u28.state !== IDLE) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%0d exp=%0d",
                 i, u28.state, IDLE);
      end
    end
    checks++;
    if (strobes !== 0) begin
      failures++;
      $display("FAIL reset_strobes got=%0d exp=0", strobes);
    end
    checks++;
    if ({d28, l28, o28} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outs d=%0d l=%b o=%b exp=0",
               d28, l28, o28);
    end
    checks++;
    if ({d8, l8, o8} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outs8 d=%0d l=%b o=%b exp=0",
               d8, l8, o8);
    end
  endtask

  task automatic test_divider();
    int cnt;
    int strobes;
    logic tick;
    do_restart();
    cnt     = 4;
    strobes = 0;
    for (int c = 0; c < 30; c++) begin
      tick = (cnt == 0);
      cnt  = tick ? 4 : cnt - 1;
      cyc(tick);
      if (v28) begin
        strobes++;
        checks++;
        if (d28 !== 28'd4) begin
          failures++;
          $display("FAIL div_value n=%0d got=%0d exp=4",
                   strobes, d28);
        end
        checks++;
        if (l28 !== (strobes >= 2)) begin
          failures++;
          $display("FAIL div_lock n=%0d got=%b exp=%b",
                   strobes, l28, strobes >= 2);
        end
      end
    end
    checks++;
    if (strobes !== 5) begin
      failures++;
      $display("FAIL div_strobes got=%0d exp=5", strobes);
    end
  endtask

  task automatic test_spacing();
    int   per [3];
    int   exd [3];
    logic exl [3];
    per = '{5, 5, 7};
    exd = '{4, 4, 6};
    exl = '{1'b0, 1'b1, 1'b0};
    do_restart();
    cyc(1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < per[i] - 1; k++) begin
        cyc(1'b0);
        checks++;
        if (v28 !== 1'b0) begin
          failures++;
          $display("FAIL sp_gap i=%0d k=%0d got=%b exp=0",
                   i, k, v28);
        end
      end
      cyc(1'b1);
      checks++;
      if (v28 !== 1'b1 || d28 !== 28'(exd[i])) begin
        failures++;
        $display("FAIL sp_strobe i=%0d v=%b d=%0d exp v=1 d=%0d",
                 i, v28, d28, exd[i]);
      end
      checks++;
      if (l28 !== exl[i]) begin
        failures++;
        $display("FAIL sp_lock i=%0d got=%b exp=%b",
                 i, l28, exl[i]);
      end
    end
    cyc(1'b0);
    checks++;
    if (v28 !== 1'b0 || d28 !== 28'd6) begin
      failures++;
      $display("FAIL sp_hold v=%b d=%0d exp v=0 d=6", v28, d28);
    end
  endtask

  task automatic test_overflow();
    do_restart();
    cyc(1'b1);
    repeat (2) begin
      repeat (3) cyc(1'b0);
      cyc(1'b1);
    end
    checks++;
    if (d8 !== 8'd3 || l8 !== 1'b1) begin
      failures++;
      $display("FAIL ov_pre d=%0d l=%b exp d=3 l=1", d8, l8);
    end
    repeat (254) cyc(1'b0);
    checks++;
    if (o8 !== 1'b0) begin
      failures++;
      $display("FAIL ov_early got=%b exp=0", o8);
    end
    cyc(1'b0);
    checks++;
    if (o8 !== 1'b1 || l8 !== 1'b0 || u8.state !== SAT) begin
      failures++;
      $display("FAIL ov_set o=%b l=%b st=%0d exp o=1 l=0 st=%0d",
               o8, l8, u8.state, SAT);
    end
    repeat (45) cyc(1'b0);
    checks++;
    if (o8 !== 1'b1 || u8.state !== SAT) begin
      failures++;
      $display("FAIL ov_hold o=%b st=%0d exp o=1 st=%0d",
               o8, u8.state, SAT);
    end
    cyc(1'b1);
    checks++;
    if (v8 !== 1'b0 || o8 !== 1'b1 || d8 !== 8'd3) begin
      failures++;
      $display("FAIL ov_tick v=%b o=%b d=%0d exp v=0 o=1 d=3",
               v8, o8, d8);
    end
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (v8 !== 1'b1 || d8 !== 8'd2 || o8 !== 1'b0 || l8 !== 1'b0)
    begin
      failures++;
      $display("FAIL ov_recover v=%b d=%0d o=%b l=%b exp 1 2 0 0",
               v8, d8, o8, l8);
    end
  endtask

  task automatic test_restart();
    do_restart();
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    pulse   = 1'b1;
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    checks++;
    if (v28 !== 1'b0 || u28.state !== IDLE || l28 !== 1'b0) begin
      failures++;
      $display("FAIL rs_prio v=%b st=%0d l=%b exp v=0 st=%0d l=0",
               v28, u28.state, l28, IDLE);
    end
    checks++;
    if (d28 !== 28'd6) begin
      failures++;
      $display("FAIL rs_divhold got=%0d exp=6", d28);
    end
    cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (v28 !== 1'b0) begin
      failures++;
      $display("FAIL rs_first got=%b exp=0", v28);
    end
    repeat (5) cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (v28 !== 1'b1 || d28 !== 28'd5) begin
      failures++;
      $display("FAIL rs_meas v=%b d=%0d exp v=1 d=5", v28, d28);
    end
  endtask

  task automatic test_min_period();
    do_restart();
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (v28 !== 1'b1 || d28 !== 28'd1) begin
      failures++;
      $display("FAIL mp_two v=%b d=%0d exp v=1 d=1", v28, d28);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1);
      checks++;
      if (v28 !== 1'b0) begin
        failures++;
        $display("FAIL mp_held i=%0d got=%b exp=0", i, v28);
      end
    end
    cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (v28 !== 1'b1 || d28 !== 28'd3) begin
      failures++;
      $display("FAIL mp_after v=%b d=%0d exp v=1 d=3", v28, d28);
    end
  endtask

`ifdef RATE_METER_STATS_EN
  task automatic test_stats();
    clear = 1'b1;
    pulse = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    checks++;
    if (mn28 !== 28'hFFFFFFF || mx28 !== 28'd0) begin
      failures++;
      $display("FAIL st_reset min=%0h max=%0h exp fffffff 0",
               mn28, mx28);
    end
    cyc(1'b0);
    cyc(1'b1);
    repeat (8) cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (mn28 !== 28'd8 || mx28 !== 28'd8) begin
      failures++;
      $display("FAIL st_first min=%0d max=%0d exp 8 8", mn28, mx28);
    end
    repeat (2) cyc(1'b0);
    cyc(1'b1);
    repeat (11) cyc(1'b0);
    cyc(1'b1);
    checks++;
    if (mn28 !== 28'd2 || mx28 !== 28'd11 || d28 !== 28'd11) begin
      failures++;
      $display("FAIL st_final min=%0d max=%0d d=%0d exp 2 11 11",
               mn28, mx28, d28);
    end
    do_restart();
    checks++;
    if (mn28 !== 28'd2 || mx28 !== 28'd11) begin
      failures++;
      $display("FAIL st_restart min=%0d max=%0d exp 2 11",
               mn28, mx28);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    restart  = 1'b0;
    pulse    = 1'b1;
    test_reset();
    test_divider();
    test_spacing();
    test_restart();
    test_min_period();
    test_overflow();
`ifdef RATE_METER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rate_meter.md
Name: rate_meter

Overview:
- Measures the spacing of single-cycle tick pulses, such as those produced by the game's rate dividers.
- Reports the reload value that a rate divider would need to reproduce that spacing.
- Counterpart to the divider: divisor out of the meter equals the divider load value that generated the ticks.
- Used for speed/difficulty readback and self-check of timing chains. Also reports lock (stable rate) and overflow.

Parameters:
WIDTH, 28, width of cycle counter and divisor output (matches divider value width)
LOCK_MATCH, 2, consecutive identical measurements required to assert locked (range 1..15)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
restart  input  1  synchronous; abandon current measurement, return to IDLE
pulse_in  input  1  tick stream under measurement; rising edge = event
divisor  output  WIDTH  last valid measured period minus 1
divisor_valid  output  1  one-cycle strobe when divisor updates
locked  output  1  LOCK_MATCH consecutive equal measurements seen
overflow  output  1  counter saturated since last valid measurement

Behaviour:
- Reset (clear=1, async):
  - state=IDLE, counter=0, divisor=0, divisor_valid=0, locked=0, overflow=0, match count=0.
  - Edge-detect history register = 1, so a level already high at reset release is not an event.
- Event: pulse_in=1 and history=0, sampled on a rising clock edge; history<=pulse_in every cycle.
  - Consequence: pulse_in held high counts once. Minimum measurable period is 2 cycles (divisor 1).
- States IDLE, MEASURE, SAT; encoding lives in the package.
- IDLE:
  - event -> MEASURE, counter<=1; no strobe.
  - no event -> stay.
- MEASURE, no event:
  - counter<=counter+1.
  - If counter is all-ones -> SAT, overflow<=1, locked<=0, match<=0; counter holds.
- MEASURE, event (period P = current counter value):
  - divisor<=P-1, divisor_valid<=1 for exactly one cycle, overflow<=0, counter<=1, stay MEASURE.
  - Latency: outputs are visible the cycle after the sampled edge.
- SAT:
  - no event -> hold.
  - event -> MEASURE, counter<=1, no strobe (the interval is invalid), overflow stays 1 until the next valid measurement.
- Lock tracking, applied on each valid measurement:
  - First measurement after IDLE/SAT: match=1.
  - New divisor equal to the previous divisor: match<=match+1, saturating at LOCK_MATCH. Otherwise match<=1.
  - locked = (match >= LOCK_MATCH), registered.
  - With LOCK_MATCH=1, locked asserts on every valid measurement.
- restart=1 has priority over an event in the same cycle:
  - state<=IDLE, counter<=0, locked<=0, match<=0, divisor_valid<=0.
  - divisor and overflow hold their values.
- divisor holds between strobes; it is never cleared except by reset.
- Counter arithmetic is unsigned WIDTH bits and saturates, never wraps. Reported periods span 2..2^WIDTH-1.

Optional Feature:
- Macro RATE_METER_STATS_EN.
- Defined:
  - Adds outputs min_divisor and max_divisor (WIDTH each), reset to all-ones and 0 respectively.
  - Both update on every valid measurement with the running min/max, registered alongside divisor.
  - restart does not clear them; only clear does.
- Undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Package rate_meter_pkg:
  - state typedef (IDLE, MEASURE, SAT)
  - default WIDTH constant (28)
  - COUNT_MAX constant (all-ones of WIDTH)
- Sub-module rising_edge_detect: one-bit history register with reset value parameter, producing the event strobe.
- FSM, counter, lock and stats logic stay in rate_meter.

Test Plan:
- Reset release with pulse_in=1, then hold high 10 cycles -> no event, state IDLE, all outputs 0.
- Drive from a rate divider loaded with 4, enable held high -> first strobe after 2nd tick with divisor=4; each later strobe divisor=4; locked=1 after 2nd strobe.
- Ticks spaced 5, 5, 7 cycles -> divisor 4, 4, 6; locked 0,1,0; divisor_valid exactly one cycle each.
- WIDTH=8, single tick then none for 300 cycles -> overflow=1 at counter 255, locked=0; next tick no strobe; following tick 3 cycles later -> divisor=2, overflow=0.
- restart in the same cycle as a tick during MEASURE -> IDLE, no strobe; next two ticks 6 apart -> divisor=5.
- RATE_METER_STATS_EN defined, periods 9, 3, 12 -> min_divisor=2, max_divisor=11 after third strobe.
